imlt_share_arbiter: RTL and testbench

- Shares one pipelined integer multiplier (iMlt_Unit plus its pipeline registers) among NUM_REQ lane requesters in a TPU backend.
- Arbitrates round-robin, issues at most one multiply per cycle and tracks in-flight operations with a tag pipeline.
- Routes each product back to its originating lane and exports busy and occupancy status to the issue stage.

---
 rtl/imlt_share_arbiter_if.sv | 36 +++
 rtl/imlt_share_arbiter.sv | 132 +++++++++++++
 tb/tb_imlt_share_arbiter.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/imlt_share_arbiter_if.sv
// Lane/multiplier bus bundle for the shared multiplier arbiter.
// No latency of its own; pure wiring between issue stage, arbiter and multiplier.
// Backpressure is carried by I_Stall; the slave modport is the arbiter side.
interface imlt_share_arbiter_if #(
   parameter int NUM_REQ    = 4,
   parameter int WIDTH_DATA = 32
);
   logic [NUM_REQ-1:0]            I_Req;
   logic [NUM_REQ*WIDTH_DATA-1:0] I_Data1;
   logic [NUM_REQ*WIDTH_DATA-1:0] I_Data2;
   logic [NUM_REQ-1:0]            I_Signed;
   logic                          I_Stall;
   logic [NUM_REQ-1:0]            O_Grant;
   logic                          O_Mlt_En;
   logic [WIDTH_DATA-1:0]         O_Mlt_Data1;
   logic [WIDTH_DATA-1:0]         O_Mlt_Data2;
   logic                          O_Mlt_Signed;
   logic                          I_Mlt_Valid;
   logic [WIDTH_DATA-1:0]         I_Mlt_Data;
   logic [NUM_REQ-1:0]            O_Valid;
   logic [WIDTH_DATA-1:0]         O_Data;
   logic [NUM_REQ-1:0]            O_Busy;
   logic [2:0]                    O_InFlight;

   modport slave (
      input  I_Req, I_Data1, I_Data2, I_Signed, I_Stall, I_Mlt_Valid, I_Mlt_Data,
      output O_Grant, O_Mlt_En, O_Mlt_Data1, O_Mlt_Data2, O_Mlt_Signed,
             O_Valid, O_Data, O_Busy, O_InFlight
   );

   modport master (
      output I_Req, I_Data1, I_Data2, I_Signed, I_Stall, I_Mlt_Valid, I_Mlt_Data,
      input  O_Grant, O_Mlt_En, O_Mlt_Data1, O_Mlt_Data2, O_Mlt_Signed,
             O_Valid, O_Data, O_Busy, O_InFlight
   );
endinterface

// File: rtl/imlt_share_arbiter.sv
// Round-robin share of one pipelined multiplier among NUM_REQ lanes, with tag-based result return.
// Grant is combinational; results reach the lane MLT_LATENCY+1 cycles after grant.
// I_Stall freezes grants, tags, busy flags and result pulses; a busy lane cannot be re-granted.
module imlt_share_arbiter #(
   parameter int NUM_REQ     = 4,
   parameter int WIDTH_DATA  = 32,
   parameter int MLT_LATENCY = 2
) (
   input logic                 clock,
   input logic                 reset,
   imlt_share_arbiter_if.slave bus
);
   localparam int IDXW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   logic [IDXW-1:0]        ptr_q, ptr_d;
   logic [MLT_LATENCY-1:0] tag_vld_q;
   logic [IDXW-1:0]        tag_lane_q [MLT_LATENCY];
   logic [NUM_REQ-1:0]     busy_q, busy_d;
   logic [NUM_REQ-1:0]     valid_q;
   logic [WIDTH_DATA-1:0]  data_q;
   logic [2:0]             inflight_q, inflight_d;
   logic [2:0]             drain_q;

   logic [NUM_REQ-1:0]     elig;
   logic [NUM_REQ-1:0]     grant;
   logic [IDXW-1:0]        grant_idx;
   logic                   grant_any;
   logic                   retire;
   logic [NUM_REQ-1:0]     ret_oh;
   logic [WIDTH_DATA-1:0]  mlt_d1, mlt_d2;
   logic                   mlt_sgn;
   int                     lane;

   // Reset gates eligibility so the combinational grant is quiet while reset is held.
   assign elig   = bus.I_Req & ~busy_q & {NUM_REQ{~bus.I_Stall & reset}};
   assign retire = ~bus.I_Stall & tag_vld_q[MLT_LATENCY-1];

   // Round-robin search starting at the pointer, wrapping modulo NUM_REQ.
   always_comb begin
      grant     = '0;
      grant_idx = '0;
      grant_any = 1'b0;
      lane      = 0;
      for (int j = 0; j < NUM_REQ; j++) begin
         lane = (int'(ptr_q) + j) % NUM_REQ;
         if (!grant_any && elig[lane]) begin
            grant_any   = 1'b1;
            grant_idx   = IDXW'(lane);
            grant[lane] = 1'b1;
         end
      end
   end

   // Operand mux for the granted lane; zero when idle.
   always_comb begin
      mlt_d1  = '0;
      mlt_d2  = '0;
      mlt_sgn = 1'b0;
      if (grant_any) begin
         mlt_d1  = bus.I_Data1[int'(grant_idx)*WIDTH_DATA +: WIDTH_DATA];
         mlt_d2  = bus.I_Data2[int'(grant_idx)*WIDTH_DATA +: WIDTH_DATA];
         mlt_sgn = bus.I_Signed[grant_idx];
      end
   end

   // Next-state for pointer, busy flags and occupancy.
   always_comb begin
      ret_oh = '0;
      if (retire) ret_oh[tag_lane_q[MLT_LATENCY-1]] = 1'b1;
      busy_d     = (busy_q & ~ret_oh) | grant;
      inflight_d = inflight_q + 3'(grant_any) - 3'(retire);
      ptr_d      = ptr_q;
      if (grant_any)
         ptr_d = (int'(grant_idx) == NUM_REQ-1) ? '0 : grant_idx + 1'b1;
   end

   // Tag pipeline: stage 0 captures the grant, all stages hold during stall.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         tag_vld_q <= '0;
         for (int i = 0; i < MLT_LATENCY; i++) tag_lane_q[i] <= '0;
      end else if (!bus.I_Stall) begin
         tag_vld_q[0]  <= grant_any;
         tag_lane_q[0] <= grant_idx;
         for (int i = 1; i < MLT_LATENCY; i++) begin
            tag_vld_q[i]  <= tag_vld_q[i-1];
            tag_lane_q[i] <= tag_lane_q[i-1];
         end
      end
   end

   // Pointer, busy, occupancy and registered result return.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         ptr_q      <= '0;
         busy_q     <= '0;
         inflight_q <= '0;
         valid_q    <= '0;
         data_q     <= '0;
      end else begin
         ptr_q      <= ptr_d;
         busy_q     <= busy_d;
         inflight_q <= inflight_d;
         valid_q    <= '0;
         if (retire && bus.I_Mlt_Valid) begin
            valid_q <= ret_oh;
            data_q  <= bus.I_Mlt_Data;
         end
      end
   end

   // Results already inside the multiplier at reset surface for up to MLT_LATENCY
   // advances afterwards; they are orphans and must not count as protocol errors.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset)                          drain_q <= 3'(MLT_LATENCY);
      else if (!bus.I_Stall && drain_q != 0) drain_q <= drain_q - 3'd1;
   end

   // Multiplier valid must line up with the last tag stage.
   a_mlt_align: assert property (@(posedge clock) disable iff (!reset)
      (!bus.I_Stall && drain_q == 3'd0) |-> (bus.I_Mlt_Valid == tag_vld_q[MLT_LATENCY-1]));

   assign bus.O_Grant      = grant;
   assign bus.O_Mlt_En     = grant_any;
   assign bus.O_Mlt_Data1  = mlt_d1;
   assign bus.O_Mlt_Data2  = mlt_d2;
   assign bus.O_Mlt_Signed = mlt_sgn;
   assign bus.O_Valid      = valid_q;
   assign bus.O_Data       = data_q;
   assign bus.O_Busy       = busy_q;
   assign bus.O_InFlight   = inflight_q;
endmodule

// File: tb/tb_imlt_share_arbiter.sv
// Self-checking bench: multiplier model, per-lane countdown reference and directed plus random stimulus.
// Reference expects each result MLT_LATENCY+1 non-stall edges after its grant.
// Stall and reset are randomised; stale multiplier results after reset must be dropped.
module tb_imlt_share_arbiter;
   localparam int N = 4;
   localparam int W = 32;
   localparam int L = 2;

   logic clock = 1'b0;
   logic reset = 1'b0;
   int   n_chk  = 0;
   int   n_fail = 0;

   always #5 clock = ~clock;

   imlt_share_arbiter_if #(.NUM_REQ(N), .WIDTH_DATA(W)) bus ();

   imlt_share_arbiter #(.NUM_REQ(N), .WIDTH_DATA(W), .MLT_LATENCY(L)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Multiplier model: fixed latency, holds on stall, unaffected by the arbiter reset.
   logic         cap_en = 1'b0;
   logic [W-1:0] cap_prod = '0;
   logic [L-1:0] mv = '0;
   logic [W-1:0] md [L];
   initial for (int i = 0; i < L; i++) md[i] = '0;

   always @(negedge clock) begin
      cap_en   <= bus.O_Mlt_En;
      cap_prod <= bus.O_Mlt_Data1 * bus.O_Mlt_Data2;
   end

   always @(posedge clock) begin
      if (!bus.I_Stall) begin
         mv[0] <= cap_en;
         md[0] <= cap_prod;
         for (int i = 1; i < L; i++) begin
            mv[i] <= mv[i-1];
            md[i] <= md[i-1];
         end
      end
   end

   assign bus.I_Mlt_Valid = mv[L-1];
   assign bus.I_Mlt_Data  = md[L-1];

   // Reference: per-lane outstanding op with edges-to-retire countdown.
   int           m_ptr = 0;
   bit [N-1:0]   m_busy = '0;
   int           m_rem [N];
   logic [W-1:0] m_prod [N];
   logic [N-1:0] m_valid = '0;
   logic [W-1:0] m_data = '0;

   always @(negedge clock) begin
      int           ek;
      logic [N-1:0] eg;
      logic [W-1:0] ed1, ed2;
      logic         esg;
      if (!reset) begin
         m_ptr = 0; m_busy = '0; m_valid = '0; m_data = '0;
         for (int i = 0; i < N; i++) m_rem[i] = 0;
      end
      ek = -1;
      if (reset && !bus.I_Stall)
         for (int j = 0; j < N; j++) begin
            int k;
            k = (m_ptr + j) % N;
            if (ek < 0 && bus.I_Req[k] && !m_busy[k]) ek = k;
         end
      eg = '0; ed1 = '0; ed2 = '0; esg = 1'b0;
      if (ek >= 0) begin
         eg[ek] = 1'b1;
         ed1 = bus.I_Data1[ek*W +: W];
         ed2 = bus.I_Data2[ek*W +: W];
         esg = bus.I_Signed[ek];
      end
      chk("grant",    64'(bus.O_Grant),      64'(eg));
      chk("mlt_en",   64'(bus.O_Mlt_En),     64'(ek >= 0));
      chk("mlt_d1",   64'(bus.O_Mlt_Data1),  64'(ed1));
      chk("mlt_d2",   64'(bus.O_Mlt_Data2),  64'(ed2));
      chk("mlt_sgn",  64'(bus.O_Mlt_Signed), 64'(esg));
      chk("valid",    64'(bus.O_Valid),      64'(m_valid));
      chk("data",     64'(bus.O_Data),       64'(m_data));
      chk("busy",     64'(bus.O_Busy),       64'(m_busy));
      chk("inflight", 64'(bus.O_InFlight),   64'($countones(m_busy)));
      if (reset) begin
         m_valid = '0;
         if (!bus.I_Stall) begin
            for (int i = 0; i < N; i++)
               if (m_busy[i]) begin
                  m_rem[i]--;
                  if (m_rem[i] == 0) begin
                     m_busy[i]  = 1'b0;
                     m_valid[i] = 1'b1;
                     m_data     = m_prod[i];
                  end
               end
            if (ek >= 0) begin
               m_busy[ek] = 1'b1;
               m_rem[ek]  = L;
               m_prod[ek] = ed1 * ed2;
               m_ptr      = (ek + 1) % N;
            end
         end
      end
   end

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic rand_ops();
      for (int i = 0; i < N; i++) begin
         bus.I_Data1[i*W +: W] = $urandom;
         bus.I_Data2[i*W +: W] = $urandom;
      end
      bus.I_Signed = N'($urandom);
   endtask

   initial begin
      bus.I_Req   = '1;
      bus.I_Stall = 1'b0;
      rand_ops();

      // Reset held with all lanes requesting.
      repeat (3) @(posedge clock);
      @(negedge clock);
      chk("rst_grant", 64'(bus.O_Grant), 64'h0);
      chk("rst_en",    64'(bus.O_Mlt_En), 64'h0);
      step(); reset = 1'b1;
      @(negedge clock);
      chk("first_grant", 64'(bus.O_Grant), 64'h1);
      chk("first_en",    64'(bus.O_Mlt_En), 64'h1);

      // Continuous requests from all lanes.
      repeat (20) begin step(); rand_ops(); end
      @(negedge clock);
      chk("inflight_sat", 64'(bus.O_InFlight), 64'h2);
      step(); bus.I_Req = '0;
      repeat (6) step();

      // Lane 2 alone, signed -3 * 7.
      bus.I_Req = 4'b0100;
      bus.I_Data1[2*W +: W] = 32'hFFFF_FFFD;
      bus.I_Data2[2*W +: W] = 32'd7;
      bus.I_Signed = 4'b0100;
      @(negedge clock);
      chk("l2_grant", 64'(bus.O_Grant), 64'h4);
      chk("l2_sgn",   64'(bus.O_Mlt_Signed), 64'h1);
      repeat (3) step();
      @(negedge clock);
      chk("l2_valid",  64'(bus.O_Valid), 64'h4);
      chk("l2_data",   64'(bus.O_Data), 64'hFFFF_FFEB);
      chk("l2_regrant", 64'(bus.O_Grant), 64'h4);
      step(); bus.I_Req = '0;
      repeat (6) step();

      // Two ops in flight, then a 2-cycle stall (pointer is 3: lane 0 then lane 1).
      bus.I_Req = 4'b0011;
      step();
      step(); bus.I_Req = '0; bus.I_Stall = 1'b1;
      @(negedge clock);
      chk("stall_inflight", 64'(bus.O_InFlight), 64'h2);
      step();
      @(negedge clock);
      chk("stall_valid", 64'(bus.O_Valid), 64'h0);
      step(); bus.I_Stall = 1'b0;
      @(negedge clock);
      chk("post_stall_v0", 64'(bus.O_Valid), 64'h0);
      step();
      @(negedge clock);
      chk("post_stall_v1", 64'(bus.O_Valid), 64'h1);
      step();
      @(negedge clock);
      chk("post_stall_v2", 64'(bus.O_Valid), 64'h2);
      repeat (4) step();

      // Pointer now 2: lanes 1 and 3 requesting wrap 3 then 1.
      bus.I_Req = 4'b1010;
      @(negedge clock);
      chk("wrap_first", 64'(bus.O_Grant), 64'h8);
      step();
      @(negedge clock);
      chk("wrap_second", 64'(bus.O_Grant), 64'h2);
      step(); bus.I_Req = '0;
      repeat (5) step();

      // Reset pulse with ops in flight; stale multiplier results must vanish.
      bus.I_Req = '1;
      repeat (3) step();
      reset = 1'b0; bus.I_Req = '0;
      @(negedge clock);
      chk("mid_rst_busy",     64'(bus.O_Busy), 64'h0);
      chk("mid_rst_inflight", 64'(bus.O_InFlight), 64'h0);
      chk("mid_rst_valid",    64'(bus.O_Valid), 64'h0);
      step(); reset = 1'b1;
      repeat (3) begin
         step();
         @(negedge clock);
         chk("stale_valid", 64'(bus.O_Valid), 64'h0);
      end

      // Randomised traffic with stalls and occasional resets.
      repeat (600) begin
         step();
         reset       = ($urandom_range(0, 99) < 2) ? 1'b0 : 1'b1;
         bus.I_Req   = N'($urandom);
         bus.I_Stall = ($urandom_range(0, 99) < 15);
         rand_ops();
      end
      reset = 1'b1; bus.I_Stall = 1'b0; bus.I_Req = '0;
      repeat (8) step();
      @(negedge clock);
      #1;
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
